// File: rtl/seq_gen_pkg.sv
// Shared types and sizing helpers for the seq_generator serial transmitter.
package seq_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_PAR   = 2'd2,
        ST_GAP   = 2'd3
    } state_e;

    localparam int GAP_CNT_W = 4;

    // bit_cnt indexes the data bit currently on the line (0..width-1).
    function automatic int bit_cnt_width(input int width);
        return (width > 32'sd2) ? $clog2(width) : 32'sd1;
    endfunction

endpackage

// File: rtl/seq_gen_hold.sv
// One-entry holding register between the valid/ready input and the shifter.
module seq_gen_hold
    import seq_gen_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_i,
    input  logic             valid_i,
    input  logic             load_i,
    output logic             ready_o,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o
);

    logic             full_q, full_d;
    logic [WIDTH-1:0] data_q, data_d;

    // Next-state: the FSM load empties the entry; an accept fills it.
    always_comb begin
        full_d = full_q;
        data_d = data_q;
        if (load_i) begin
            full_d = 1'b0;
        end else if (valid_i && !full_q) begin
            full_d = 1'b1;
            data_d = data_i;
        end else begin
            full_d = full_q;
        end
    end

    // Holding register state.
    always_ff @(posedge clk) begin
        if (reset) begin
            full_q <= 1'b0;
            data_q <= {WIDTH{1'b0}};
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

    assign ready_o = ~full_q;
    assign data_o  = data_q;
    assign full_o  = full_q;

endmodule

// File: rtl/seq_generator.sv
// Framed MSB-first serial transmitter with programmable idle gap.
// Optional even-parity bit per frame when SEQ_GEN_PARITY_EN is defined.
module seq_generator
    import seq_gen_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int GAP   = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid,
    output logic             data_ready,
    output logic             out,
    output logic             out_valid,
    output logic             done,
    output logic             busy
);

    localparam int BCW = bit_cnt_width(WIDTH);
    localparam logic [BCW-1:0]       BIT_LAST   = BCW'(WIDTH - 1);
    localparam logic [BCW-1:0]       BIT_PENULT = BCW'(WIDTH - 2);
    localparam logic [GAP_CNT_W-1:0] GAP_LAST   = GAP_CNT_W'((GAP > 32'sd0) ? (GAP - 1) : 0);

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     shift_q, shift_d;
    logic [BCW-1:0]       bit_cnt_q, bit_cnt_d;
    logic [GAP_CNT_W-1:0] gap_cnt_q, gap_cnt_d;
    logic                 out_q, out_d;
    logic                 out_valid_q, out_valid_d;
    logic                 done_q, done_d;
    logic                 seek_s;
    logic                 load_s;
    logic                 hold_full_s;
    logic [WIDTH-1:0]     hold_data_s;
`ifdef SEQ_GEN_PARITY_EN
    logic                 parity_q, parity_d;
`endif

    seq_gen_hold #(.WIDTH(WIDTH)) u_hold (
        .clk     (clk),
        .reset   (reset),
        .data_i  (data_in),
        .valid_i (data_valid),
        .load_i  (load_s),
        .ready_o (data_ready),
        .data_o  (hold_data_s),
        .full_o  (hold_full_s)
    );

    // FSM next-state and next output bit; seek_s marks a frame boundary where a new word may load.
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        out_d       = 1'b0;
        out_valid_d = 1'b0;
        done_d      = 1'b0;
        seek_s      = 1'b0;
        load_s      = 1'b0;
`ifdef SEQ_GEN_PARITY_EN
        parity_d    = parity_q;
`endif
        case (state_q)
            ST_IDLE: begin
                seek_s = 1'b1;
            end
            ST_SHIFT: begin
                if (bit_cnt_q != BIT_LAST) begin
                    out_d       = shift_q[WIDTH-1];
                    out_valid_d = 1'b1;
                    shift_d     = {shift_q[WIDTH-2:0], 1'b0};
                    bit_cnt_d   = bit_cnt_q + BCW'(1);
`ifdef SEQ_GEN_PARITY_EN
                    done_d      = 1'b0;
`else
                    done_d      = (bit_cnt_q == BIT_PENULT);
`endif
                end else begin
`ifdef SEQ_GEN_PARITY_EN
                    state_d     = ST_PAR;
                    out_d       = parity_q;
                    out_valid_d = 1'b1;
                    done_d      = 1'b1;
`else
                    if (GAP > 32'sd0) begin
                        state_d   = ST_GAP;
                        gap_cnt_d = {GAP_CNT_W{1'b0}};
                    end else begin
                        seek_s    = 1'b1;
                    end
`endif
                end
            end
`ifdef SEQ_GEN_PARITY_EN
            ST_PAR: begin
                if (GAP > 32'sd0) begin
                    state_d   = ST_GAP;
                    gap_cnt_d = {GAP_CNT_W{1'b0}};
                end else begin
                    seek_s    = 1'b1;
                end
            end
`endif
            ST_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    seek_s    = 1'b1;
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A waiting word starts immediately, skipping IDLE, so frames run back to back.
        if (seek_s && hold_full_s) begin
            load_s      = 1'b1;
            state_d     = ST_SHIFT;
            out_d       = hold_data_s[WIDTH-1];
            out_valid_d = 1'b1;
            shift_d     = {hold_data_s[WIDTH-2:0], 1'b0};
            bit_cnt_d   = {BCW{1'b0}};
`ifdef SEQ_GEN_PARITY_EN
            parity_d    = ^hold_data_s;
`endif
        end else if (seek_s) begin
            state_d = ST_IDLE;
        end else begin
            load_s  = 1'b0;
        end
    end

    // State, datapath and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            shift_q     <= {WIDTH{1'b0}};
            bit_cnt_q   <= {BCW{1'b0}};
            gap_cnt_q   <= {GAP_CNT_W{1'b0}};
            out_q       <= 1'b0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
`ifdef SEQ_GEN_PARITY_EN
            parity_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
`ifdef SEQ_GEN_PARITY_EN
            parity_q    <= parity_d;
`endif
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign done      = done_q;
    assign busy      = (state_q != ST_IDLE) || hold_full_s;

endmodule

// File: tb/tb_seq_generator.sv
// Self-checking bench for seq_generator: directed frames, back-to-back GAP=0,
// 100 random words against a word-level scoreboard, and mid-frame reset.
module tb_seq_generator;

    localparam int W     = 8;
    localparam int GAP_A = 1;
`ifdef SEQ_GEN_PARITY_EN
    localparam int FLEN  = W + 1;
`else
    localparam int FLEN  = W;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         a_reset, a_valid, a_ready, a_out, a_ovalid, a_done, a_busy;
    logic [W-1:0] a_data;
    logic         b_reset, b_valid, b_ready, b_out, b_ovalid, b_done, b_busy;
    logic [W-1:0] b_data;

    seq_generator #(.WIDTH(W), .GAP(GAP_A)) dut_a (
        .clk(clk), .reset(a_reset), .data_in(a_data), .data_valid(a_valid),
        .data_ready(a_ready), .out(a_out), .out_valid(a_ovalid), .done(a_done), .busy(a_busy)
    );

    seq_generator #(.WIDTH(W), .GAP(0)) dut_b (
        .clk(clk), .reset(b_reset), .data_in(b_data), .data_valid(b_valid),
        .data_ready(b_ready), .out(b_out), .out_valid(b_ovalid), .done(b_done), .busy(b_busy)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Reference: bit i of a frame is data MSB-first, then the even parity of the word.
    function automatic logic frame_bit(input logic [W-1:0] w, input int i);
        if (i < W) return w[W-1-i];
        return 1'(($countones(w) % 2));
    endfunction

    function automatic logic [FLEN-1:0] frame_of(input logic [W-1:0] w);
        logic [FLEN-1:0] f;
        for (int i = 0; i < FLEN; i++) f[FLEN-1-i] = frame_bit(w, i);
        return f;
    endfunction

    // Word-level scoreboard monitor on dut_a during the random phase.
    logic [W-1:0]    exp_q[$];
    bit              mon_en = 1'b0;
    int              nbits = 0, idle = 0, rx = 0, tx = 0;
    logic [FLEN-1:0] rx_frame = '0;
    logic [W-1:0]    mw;

    always @(posedge clk) begin
        #1;
        if (mon_en) begin
            if (a_ovalid) begin
                if (nbits == 0 && rx > 0) check_val("gap_len", 32'(idle >= GAP_A), 32'd1);
                rx_frame = {rx_frame[FLEN-2:0], a_out};
                nbits++;
                check_val("done_pos", a_done, 32'(nbits == FLEN));
                if (nbits == FLEN) begin
                    nbits = 0;
                    idle  = 0;
                    rx++;
                    check_val("queue_nonempty", 32'(exp_q.size() > 0), 32'd1);
                    if (exp_q.size() > 0) begin
                        mw = exp_q.pop_front();
                        check_val("rand_frame", rx_frame, frame_of(mw));
                    end
                end
            end else begin
                check_val("done_idle", a_done, 32'd0);
                if (nbits != 0) begin
                    check_val("frame_break", nbits, 32'd0);
                    nbits = 0;
                end
                idle++;
            end
        end
    end

    // Raw cycle log of dut_b for the back-to-back test.
    logic [1:0] b_log[$];
    bit         b_log_en = 1'b0;
    always @(posedge clk) begin
        #1;
        if (b_log_en) b_log.push_back({b_ovalid, b_out});
    end

    task automatic send_dir(input logic [W-1:0] w);
        @(negedge clk);
        check_val("dir_ready", a_ready, 32'd1);
        a_valid = 1'b1;
        a_data  = w;
        @(negedge clk);
        a_valid = 1'b0;
        a_data  = W'($urandom);
        check_val("dir_busy", a_busy, 32'd1);
        for (int i = 0; i < FLEN; i++) begin
            @(posedge clk); #1;
            check_val("dir_valid", a_ovalid, 32'd1);
            check_val("dir_bit", a_out, frame_bit(w, i));
            check_val("dir_done", a_done, 32'(i == FLEN - 1));
        end
        for (int g = 0; g < GAP_A; g++) begin
            @(posedge clk); #1;
            check_val("dir_gap", a_ovalid, 32'd0);
        end
        @(posedge clk); #1;
        check_val("dir_idle_busy", a_busy, 32'd0);
    endtask

    bit           have;
    logic [W-1:0] pend;
    int           cyc;
    int           first;
    logic [W-1:0] bw;
    logic [W-1:0] x_word;

    initial begin
        a_reset = 1'b1; b_reset = 1'b1;
        a_valid = 1'b0; b_valid = 1'b0;
        a_data  = '0;   b_data  = '0;
        repeat (3) @(negedge clk);
        a_reset = 1'b0; b_reset = 1'b0;

        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check_val("idle_a", {a_out, a_ovalid, a_done, a_ready, a_busy}, 32'b00010);
            check_val("idle_b", {b_out, b_ovalid, b_done, b_ready, b_busy}, 32'b00010);
        end

        send_dir(8'hA5);
        send_dir(8'h07);
        send_dir(8'h00);
        send_dir(8'hFF);

        // GAP=0: 0xFF then 0x00 with valid held high
        @(negedge clk);
        b_log_en = 1'b1;
        check_val("b_ready0", b_ready, 32'd1);
        b_valid = 1'b1;
        b_data  = 8'hFF;
        @(negedge clk);
        b_data = 8'h00;
        check_val("b_held_off", b_ready, 32'd0);
        @(negedge clk);
        check_val("b_ready_mid_frame", b_ready, 32'd1);
        check_val("b_shifting", b_ovalid, 32'd1);
        @(negedge clk);
        b_valid = 1'b0;
        b_data  = W'($urandom);
        repeat (2 * FLEN + 6) @(negedge clk);
        b_log_en = 1'b0;
        first = -1;
        for (int i = 0; i < b_log.size(); i++) begin
            if (first < 0 && b_log[i][1]) first = i;
        end
        check_val("b_first_idx", first, 32'd1);
        if (first >= 0 && first + 2 * FLEN < b_log.size()) begin
            for (int i = 0; i < 2 * FLEN; i++) begin
                bw = (i < FLEN) ? 8'hFF : 8'h00;
                check_val("b_stream", b_log[first + i], {1'b1, frame_bit(bw, i % FLEN)});
            end
            check_val("b_stream_end", b_log[first + 2 * FLEN][1], 32'd0);
        end else begin
            check_val("b_log_len", b_log.size(), 32'(first + 2 * FLEN + 1));
        end

        // Random words with random valid; data_in is garbage whenever ready is low
        repeat (3) @(negedge clk);
        mon_en = 1'b1;
        have   = 1'b0;
        cyc    = 0;
        while (tx < 100 && cyc < 5000) begin
            @(negedge clk);
            cyc++;
            if (!have && ($urandom_range(0, 2) != 0)) begin
                pend = W'($urandom);
                have = 1'b1;
            end
            a_valid = have;
            if (have && a_ready) begin
                a_data = pend;
                exp_q.push_back(pend);
                tx++;
                have = 1'b0;
            end else begin
                a_data = W'($urandom);
            end
        end
        @(negedge clk);
        a_valid = 1'b0;
        for (int k = 0; k < 500 && (exp_q.size() != 0 || nbits != 0); k++) @(negedge clk);
        repeat (4) @(negedge clk);
        mon_en = 1'b0;
        check_val("drain", exp_q.size(), 32'd0);
        check_val("tx_count", tx, 32'd100);
        check_val("rx_count", rx, tx);

        // Reset on bit 3 of a frame with the hold register full
        x_word = 8'h96;
        @(negedge clk);
        a_valid = 1'b1;
        a_data  = x_word;
        @(negedge clk);
        a_data = 8'h5A;
        check_val("rst_hold_off", a_ready, 32'd0);
        @(negedge clk);
        check_val("rst_ready", a_ready, 32'd1);
        @(negedge clk);
        a_valid = 1'b0;
        a_data  = W'($urandom);
        @(negedge clk);
        @(negedge clk);
        check_val("rst_bit3", a_out, frame_bit(x_word, 3));
        check_val("rst_pre", {a_ovalid, a_ready, a_busy}, 32'b101);
        a_reset = 1'b1;
        @(posedge clk); #1;
        check_val("rst_vals", {a_out, a_ovalid, a_done, a_ready, a_busy}, 32'b00010);
        @(negedge clk);
        a_reset = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            check_val("rst_quiet", {a_ovalid, a_busy}, 32'b00);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/seq_generator.md
# seq_generator

Serial pattern transmitter that drives the 1-bit serial input of the `seq_detector` sequence-detector family. Accepts parallel WIDTH-bit words over a valid/ready handshake, buffers one word, and shifts each word out MSB-first as a framed bit stream with an optional parity bit and a programmable idle gap. Used as the stimulus/transmit end of the serial link and as the source side of detector loopback tests.

## Interface
- WIDTH, 8: data bits per frame (2..32)
- GAP, 1: idle cycles after each frame (0..15)
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- data_in  in  WIDTH  parallel word to send
- data_valid  in  1  data_in valid
- data_ready  out  1  holding register empty; transfer when data_valid && data_ready at posedge
- out  out  1  serial bit, registered
- out_valid  out  1  out carries a frame bit (data or parity)
- done  out  1  one-cycle pulse while the final frame bit is on out
- busy  out  1  state != IDLE or holding register full

## Operation
- One-entry holding register (hold, hold_full); data_ready = ~hold_full, combinational from that flag only, with no same-cycle bypass.
- FSM states: IDLE, SHIFT, PAR, GAP (2-bit encoding).
- IDLE: if hold_full, load the shifter from hold, clear hold_full, set bit_cnt=0, go to SHIFT, drive the MSB. Otherwise out=0, out_valid=0.
- SHIFT: out=shifter MSB, out_valid=1, shift left each cycle. After WIDTH bits go to PAR (macro on) or to GAP/IDLE.
- PAR: out=even parity bit (XOR of the frame's data bits), out_valid=1, one cycle.
- GAP: out=0, out_valid=0 for GAP cycles, then IDLE. With GAP=0, the FSM goes straight to IDLE. If hold_full, IDLE is skipped: the load happens on the same edge and the next frame's MSB follows the last frame bit with no gap.
- hold may be refilled during SHIFT/PAR/GAP as soon as it has been moved to the shifter.
- done=1 exactly in the cycle the last frame bit is driven.
- Simultaneous accept and load: hold_full must already be 1 for a load, so ready=0 that cycle and no conflict arises.
- data_in changes while data_ready=0 are ignored.

## Timing
- Reset values: out=0, out_valid=0, done=0, busy=0, data_ready=1 (hold_full=0), state=IDLE, bit_cnt=0, gap_cnt=0.
- Reset mid-frame aborts the frame and discards hold. Outputs take their reset values on the next edge.
- Latency: for an accept at edge N with the FSM in IDLE, the MSB appears on out after edge N+1.
- Frame length: WIDTH (+1 with parity) bits of out_valid=1, then GAP cycles of out_valid=0.
- Sustained throughput: one word per WIDTH(+1)+GAP cycles.
- All outputs are registered except data_ready and busy, which are derived from registers only.

## Configuration
- SEQ_GEN_PARITY_EN defined: the PAR state is present and each frame is WIDTH+1 bits, ending with the even-parity bit.
- SEQ_GEN_PARITY_EN undefined: the PAR state is removed, frames are WIDTH bits, and done coincides with the data LSB.

## Structure
- seq_gen_pkg holds:
  - state typedef (IDLE/SHIFT/PAR/GAP)
  - the GAP counter width constant (4)
  - a function computing the bit-counter width from WIDTH
- Sub-module seq_gen_hold: the one-entry holding register with valid/ready in and a load strobe out.
- The FSM, shifter and counters live in the top module.

## Test plan
- Reset, then idle with data_valid=0 → out=0, out_valid=0, data_ready=1, busy=0 for 20 cycles.
- WIDTH=8, GAP=1, parity off, send 0xA5 → out = 1,0,1,0,0,1,0,1 on consecutive cycles starting after edge N+1; done on the eighth bit. Loopback into seq_detector yields out=1 on bits 4 and 6.
- Parity on, send 0x07 → frame 0,0,0,0,0,1,1,1,1 (parity 1). Send 0xA5 → parity bit 0.
- GAP=0, back-to-back 0xFF then 0x00 with data_valid held high → 16 contiguous out_valid bits 1×8 then 0×8. Second accept occurs while the first frame shifts.
- Hold full during a frame → data_ready=0 until the load edge. Extra valid words are held off and none are lost or duplicated; compare sent vs. received words over 100 random words.
- Assert reset on bit 3 of a frame with hold full → after the next edge all outputs are at reset values, and the remaining bits and the held word are never transmitted.
